// File: rtl/icc_branch_unit.sv
// icc_branch_unit: architectural integer condition codes, Bicc evaluation,
// in-flight setcc scoreboard and delayed-branch redirect/annul control.
// Optional feature macro: ICC_FWD_EN -- lets a branch resolve on the live
// ALU flags in the cycle the last outstanding setcc op retires.
module icc_branch_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setcc_issue,
  input  logic              alu_valid,
  input  logic              alu_setcc,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_c,
  input  logic              icc_wr,
  input  logic [3:0]        icc_wdata,
  input  logic              br_valid,
  input  logic [3:0]        br_cond,
  input  logic              br_annul,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              slot_valid,
  output logic              br_ready,
  output logic [3:0]        icc,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              annul_slot,
  output logic              cc_err
);

  typedef enum logic {IDLE, DELAY} state_t;

  state_t     state;
  logic [1:0] pend;
  logic       retire;
  logic       accept;
  logic       taken;
  logic [3:0] flags;
  logic [3:0] alu_flags;

  assign retire    = alu_valid & alu_setcc;
  assign alu_flags = {alu_n, alu_z, alu_v, alu_c};

  // Bicc condition: low three bits pick the test, bit 3 complements it
  // (cond 1000 is the complement of "never", i.e. always).
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, r;
    {n, z, v, c} = f;
    case (cond[2:0])
      3'd0:    r = 1'b0;
      3'd1:    r = z;
      3'd2:    r = z | (n ^ v);
      3'd3:    r = n ^ v;
      3'd4:    r = c | z;
      3'd5:    r = c;
      3'd6:    r = n;
      default: r = v;
    endcase
    return r ^ cond[3];
  endfunction

`ifdef ICC_FWD_EN
  logic fwd_ok;
  // The only outstanding op retires now and no WRPSR overrides it: use its flags.
  assign fwd_ok   = (pend == 2'd1) & retire & ~icc_wr;
  assign br_ready = (state == IDLE) & ((pend == 2'd0) | fwd_ok);
  assign flags    = fwd_ok ? alu_flags : icc;
`else
  assign br_ready = (state == IDLE) & (pend == 2'd0);
  assign flags    = icc;
`endif

  assign accept = br_valid & br_ready;
  assign taken  = cond_eval(br_cond, flags);

  // Architectural flags: WRPSR has priority over an ALU setcc result.
  always_ff @(posedge clk) begin
    if (reset)       icc <= 4'b0000;
    else if (icc_wr) icc <= icc_wdata;
    else if (retire) icc <= alu_flags;
  end

  // Outstanding setcc scoreboard; saturates and flags any over/underflow stickily.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend   <= 2'd0;
      cc_err <= 1'b0;
    end else begin
      case ({setcc_issue, retire})
        2'b10: if (pend == 2'd3) cc_err <= 1'b1; else pend <= pend + 2'd1;
        2'b01: if (pend == 2'd0) cc_err <= 1'b1; else pend <= pend - 2'd1;
        default: ;
      endcase
    end
  end

  // Branch FSM: accept in IDLE, pulse redirect on entry to DELAY, hold the
  // annul until the delay-slot instruction shows up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      annul_slot  <= 1'b0;
    end else begin
      redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= DELAY;
            redirect    <= taken;
            redirect_pc <= br_target;
            annul_slot  <= br_annul & (~taken | (br_cond == 4'b1000));
          end
        end
        default: begin
          if (slot_valid) begin
            state      <= IDLE;
            annul_slot <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icc_branch_unit.sv
// tb_icc_branch_unit: directed test-plan sequences plus random traffic,
// all checked against a cycle-level behavioural model of the branch unit.
module tb_icc_branch_unit;
  localparam int AW = 32;
`ifdef ICC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, setcc_issue, alu_valid, alu_setcc, alu_n, alu_z, alu_v, alu_c;
  logic icc_wr, br_valid, br_annul, slot_valid;
  logic [3:0] icc_wdata, br_cond;
  logic [AW-1:0] br_target;
  logic br_ready, redirect, annul_slot, cc_err;
  logic [3:0] icc;
  logic [AW-1:0] redirect_pc;

  icc_branch_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .setcc_issue(setcc_issue), .alu_valid(alu_valid),
    .alu_setcc(alu_setcc), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .icc_wr(icc_wr), .icc_wdata(icc_wdata), .br_valid(br_valid), .br_cond(br_cond),
    .br_annul(br_annul), .br_target(br_target), .slot_valid(slot_valid),
    .br_ready(br_ready), .icc(icc), .redirect(redirect), .redirect_pc(redirect_pc),
    .annul_slot(annul_slot), .cc_err(cc_err)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // model state
  int m_pend;
  logic [3:0] m_icc;
  logic [AW-1:0] m_pc;
  bit m_err, m_dly, m_ann, m_red, e_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_take(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, v, c, b;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (int'(cond) % 8)
      0: b = 0;
      1: b = z;
      2: b = z || (n != v);
      3: b = (n != v);
      4: b = c || z;
      5: b = c;
      6: b = n;
      default: b = v;
    endcase
    return (cond >= 8) ? !b : b;
  endfunction

  task automatic clr();
    reset = 0; setcc_issue = 0; alu_valid = 0; alu_setcc = 0;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
    icc_wr = 0; icc_wdata = 0; br_valid = 0; br_cond = 0; br_annul = 0;
    br_target = 0; slot_valid = 0;
  endtask

  // one clock: check combinational ready, advance model, check registered outputs
  task automatic cyc();
    bit ret, t;
    int np;
    logic [3:0] f;
    ret = alu_valid && alu_setcc;
    #1;
    e_ready = !m_dly && (m_pend == 0 || (FWD && m_pend == 1 && ret && !icc_wr));
    chk("br_ready", br_ready, e_ready);
    @(posedge clk);
    if (reset) begin
      m_pend = 0; m_icc = 0; m_err = 0; m_dly = 0; m_ann = 0; m_red = 0; m_pc = 0;
    end else begin
      f = (FWD && m_pend != 0) ? {alu_n, alu_z, alu_v, alu_c} : m_icc;
      m_red = 0;
      if (br_valid && e_ready) begin
        t = ref_take(br_cond, f);
        m_red = t;
        m_pc = br_target;
        m_ann = br_annul && (!t || br_cond == 4'b1000);
        m_dly = 1;
      end else if (m_dly && slot_valid) begin
        m_dly = 0; m_ann = 0;
      end
      np = m_pend + (setcc_issue ? 1 : 0) - (ret ? 1 : 0);
      if (np > 3) begin np = 3; m_err = 1; end
      else if (np < 0) begin np = 0; m_err = 1; end
      m_pend = np;
      if (icc_wr) m_icc = icc_wdata;
      else if (ret) m_icc = {alu_n, alu_z, alu_v, alu_c};
    end
    #1;
    chk("icc", icc, m_icc);
    chk("redirect", redirect, m_red);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("annul_slot", annul_slot, m_ann);
    chk("cc_err", cc_err, m_err);
  endtask

  task automatic do_reset();
    clr(); reset = 1; cyc(); reset = 0;
  endtask

  initial begin
    m_pend = 0; m_icc = 0; m_err = 0; m_dly = 0; m_ann = 0; m_red = 0; m_pc = 0;
    do_reset();
    chk("rst_ready", br_ready, 1);
    chk("rst_icc", icc, 0);

    // flag capture
    clr(); alu_valid = 1; alu_setcc = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b0101; cyc();
    chk("cap_icc", icc, 4'b0101);
    clr(); alu_valid = 1; alu_setcc = 0; {alu_n, alu_z, alu_v, alu_c} = 4'b1010; cyc();
    chk("cap_nosetcc", icc, 4'b0101);
    do_reset();

    // BE after ADDcc, target 0x40 presented throughout
    clr(); setcc_issue = 1; br_valid = 1; br_cond = 4'b0001; br_target = 32'h40; cyc();
    setcc_issue = 0; alu_valid = 1; alu_setcc = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b0100; cyc();
    alu_valid = 0; alu_setcc = 0; alu_z = 0; cyc();
    br_valid = 0;
    for (int i = 0; i < 3; i++) cyc();
    slot_valid = 1; cyc(); slot_valid = 0; cyc();

    // all 16 conds x 16 icc values x both a-bits
    for (int a = 0; a < 2; a++)
      for (int v = 0; v < 16; v++)
        for (int c = 0; c < 16; c++) begin
          clr(); icc_wr = 1; icc_wdata = 4'(v); cyc();
          clr(); br_valid = 1; br_cond = 4'(c); br_annul = 1'(a); br_target = $urandom; cyc();
          br_valid = 0; cyc();
          slot_valid = 1; cyc();
          slot_valid = 0; cyc();
        end

    // scoreboard overflow / underflow
    do_reset();
    clr(); setcc_issue = 1;
    for (int i = 0; i < 4; i++) cyc();
    chk("sb_ovf", cc_err, 1);
    do_reset();
    chk("sb_rst", cc_err, 0);
    clr(); alu_valid = 1; alu_setcc = 1; cyc();
    chk("sb_unf", cc_err, 1);
    do_reset();

    // reset in DELAY after BA a=1
    clr(); br_valid = 1; br_cond = 4'b1000; br_annul = 1; br_target = 32'h1234; cyc();
    br_valid = 0; cyc();
    reset = 1; cyc(); reset = 0;
    chk("rd_redirect", redirect, 0);
    chk("rd_annul", annul_slot, 0);
    chk("rd_ready", br_ready, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      clr();
      reset       = ($urandom_range(0, 99) == 0);
      setcc_issue = ($urandom_range(0, 3) == 0);
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_setcc   = (m_pend > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      {alu_n, alu_z, alu_v, alu_c} = 4'($urandom);
      icc_wr      = ($urandom_range(0, 15) == 0);
      icc_wdata   = 4'($urandom);
      br_valid    = ($urandom_range(0, 1) == 0);
      br_cond     = 4'($urandom);
      br_annul    = 1'($urandom);
      br_target   = $urandom;
      slot_valid  = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
